trencadis_pulse_period_meter: RTL

//  Receive-side counterpart of the periodic pulse generator: measures spacing between rising edges of a synchronous

---
 rtl/trencadis_pulse_period_meter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/trencadis_pulse_period_meter.sv
// Measures the spacing between rising edges of a synchronous pulse stream and reports it as distance-1,
// with a valid/ready sample port, a timeout state, a sticky overrun flag and lock detection against expected_i.
module trencadis_pulse_period_meter #(
  parameter int SIZE     = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            pulse_i,
  input  logic [SIZE-1:0] expected_i,
  input  logic            clear_i,
  output logic [SIZE-1:0] period_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            timeout_o,
  output logic            overrun_o,
  output logic            locked_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  // Last counter value before saturation; reaching it without an edge means the stream has gone silent.
  localparam logic [SIZE-1:0] CNT_LAST = {{(SIZE-1){1'b1}}, 1'b0};
  localparam logic [MW-1:0]   LOCK_MAX = MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TIMEOUT
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] period_q, period_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            locked_q, locked_d;
  logic [MW-1:0]   match_q, match_d;
  logic            pulse_q;

  logic            edge_w;
  logic            sample_w;
  logic            drop_w;

  assign edge_w = pulse_i & ~pulse_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    locked_d  = locked_q;
    match_d   = match_q;
    sample_w  = 1'b0;
    drop_w    = 1'b0;

    if (!enable_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
      match_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_w) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        MEASURE: begin
          if (edge_w) begin
            sample_w = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = TIMEOUT;
            end
          end
        end
        TIMEOUT: begin
          // An edge here only re-arms: the gap before it is unknown, so no sample is produced.
          locked_d = 1'b0;
          match_d  = '0;
          if (edge_w) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    drop_w = sample_w & valid_q & ~ready_i;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (sample_w && !drop_w) begin
      period_d = cnt_q;
      valid_d  = 1'b1;
    end

    if (clear_i) begin
      overrun_d = 1'b0;
    end
    if (drop_w) begin
      overrun_d = 1'b1;
    end

    // Dropped samples still count toward lock: they are real measurements, only undeliverable.
    if (sample_w) begin
      if (cnt_q == expected_i) begin
        match_d  = (match_q == LOCK_MAX) ? LOCK_MAX : match_q + 1'b1;
        locked_d = (match_d == LOCK_MAX);
      end else begin
        match_d  = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      locked_q  <= 1'b0;
      match_q   <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      locked_q  <= locked_d;
      match_q   <= match_d;
      pulse_q   <= pulse_i;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = (state_q == TIMEOUT);
  assign overrun_o = overrun_q;
  assign locked_o  = locked_q;

endmodule
